// File: rtl/fp_unpacker.sv
// Dual-operand IEEE-754 unpacker (single/double) with optional denormal pre-normalisation.
// Decodes sign, unbiased exponent, significand, leading-zero count, special flags and NaN payload.
module fp_unpacker (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] FA2,
  input  logic [63:0] FB2,
  input  logic        db,
  input  logic        normal,
  output logic        sa,
  output logic        sb,
  output logic [10:0] ea,
  output logic [10:0] eb,
  output logic [5:0]  lza,
  output logic [5:0]  lzb,
  output logic [52:0] fa,
  output logic [52:0] fb,
  output logic [3:0]  fla,
  output logic [3:0]  flb,
  output logic [52:0] nan
);

  localparam logic [52:0] QNAN_DEFAULT = 53'h08000000000000;

  logic [1:0][63:0] op_w;
  logic [1:0]       s_d, s_q;
  logic [1:0][10:0] e_d, e_q;
  logic [1:0][5:0]  lz_d, lz_q;
  logic [1:0][52:0] f_d, f_q;
  logic [1:0][3:0]  fl_d, fl_q;
  logic [1:0][51:0] qfrac_w;
  logic [52:0]      nan_d, nan_q;

  assign op_w[0] = FA2;
  assign op_w[1] = FB2;

  // Highest set bit wins; an all-zero significand reports 53.
  function automatic logic [5:0] clz53(input logic [52:0] v);
    logic [5:0] cnt;
    cnt = 6'd53;
    for (int i = 0; i < 53; i++) begin
      if (v[i]) cnt = 6'(52 - i);
    end
    return cnt;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_op
      logic [10:0] e_raw;
      logic [10:0] bias;
      logic [51:0] frac;
      logic        e_all_ones;
      logic        exp_zero;
      logic        frac_zero;
      logic [52:0] u;
      logic [5:0]  lz;
      logic [10:0] e_unb;
      logic [52:0] f_out;
      logic [3:0]  fl;

      always_comb begin
        if (db) begin
          e_raw      = op_w[gi][62:52];
          frac       = op_w[gi][51:0];
          e_all_ones = &op_w[gi][62:52];
          bias       = 11'd1023;
        end else begin
          // Single fraction is left-aligned so bit 51 is the quiet bit in both formats.
          e_raw      = {3'b000, op_w[gi][62:55]};
          frac       = {op_w[gi][54:32], 29'd0};
          e_all_ones = &op_w[gi][62:55];
          bias       = 11'd127;
        end
        exp_zero  = (e_raw == 11'd0);
        frac_zero = (frac == 52'd0);
        u         = {~exp_zero, frac};
        lz        = clz53(u);
        e_unb     = exp_zero ? (11'd1 - bias) : (e_raw - bias);
        f_out     = normal ? (u << lz) : u;
        fl[3]     = exp_zero & frac_zero;
        fl[2]     = e_all_ones & frac_zero;
        fl[1]     = e_all_ones & ~frac_zero;
        fl[0]     = e_all_ones & ~frac_zero & ~frac[51];
      end

      assign s_d[gi]     = op_w[gi][63];
      assign e_d[gi]     = e_unb;
      assign lz_d[gi]    = lz;
      assign f_d[gi]     = f_out;
      assign fl_d[gi]    = fl;
      assign qfrac_w[gi] = frac | (52'd1 << 51);
    end
  endgenerate

  always_comb begin
    nan_d = QNAN_DEFAULT;
    if (fl_d[0][1]) begin
      nan_d = {s_d[0], qfrac_w[0]};
    end else if (fl_d[1][1]) begin
      nan_d = {s_d[1], qfrac_w[1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q   <= '0;
      e_q   <= '0;
      lz_q  <= '0;
      f_q   <= '0;
      fl_q  <= '0;
      nan_q <= '0;
    end else begin
      s_q   <= s_d;
      e_q   <= e_d;
      lz_q  <= lz_d;
      f_q   <= f_d;
      fl_q  <= fl_d;
      nan_q <= nan_d;
    end
  end

  assign sa  = s_q[0];
  assign sb  = s_q[1];
  assign ea  = e_q[0];
  assign eb  = e_q[1];
  assign lza = lz_q[0];
  assign lzb = lz_q[1];
  assign fa  = f_q[0];
  assign fb  = f_q[1];
  assign fla = fl_q[0];
  assign flb = fl_q[1];
  assign nan = nan_q;

endmodule

// File: tb/tb_fp_unpacker.sv
// Directed self-checking bench for fp_unpacker: one task per scenario, hand-computed expectations.
module tb_fp_unpacker;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] FA2, FB2;
  logic        db, normal;
  logic        sa, sb;
  logic [10:0] ea, eb;
  logic [5:0]  lza, lzb;
  logic [52:0] fa, fb;
  logic [3:0]  fla, flb;
  logic [52:0] nan;

  int total = 0;
  int bad   = 0;

  fp_unpacker dut (
    .clk(clk), .rst(rst), .FA2(FA2), .FB2(FB2), .db(db), .normal(normal),
    .sa(sa), .sb(sb), .ea(ea), .eb(eb), .lza(lza), .lzb(lzb),
    .fa(fa), .fb(fb), .fla(fla), .flb(flb), .nan(nan)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle past it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; FA2 = 64'hFFF0000000000001; FB2 = 64'hFFF0000000000001; db = 1'b1; normal = 1'b1;
    step();
    $display("txn reset: rst=1 FA2=%h", FA2);
    total++; if ({sa, sb, ea, eb, lza, lzb} !== '0) begin bad++; $display("FAIL reset_scalar got=%h exp=0", {sa, sb, ea, eb, lza, lzb}); end
    total++; if ({fa, fb} !== '0) begin bad++; $display("FAIL reset_sig got=%h exp=0", {fa, fb}); end
    total++; if ({fla, flb} !== 8'h00) begin bad++; $display("FAIL reset_flags got=%h exp=00", {fla, flb}); end
    total++; if (nan !== 53'h0) begin bad++; $display("FAIL reset_nan got=%h exp=0", nan); end
    rst = 1'b0;
    step();
    $display("txn reset_release: FA2=%h", FA2);
    total++; if (fla !== 4'b0011) begin bad++; $display("FAIL release_fla got=%b exp=0011", fla); end
    total++; if (sa !== 1'b1) begin bad++; $display("FAIL release_sa got=%b exp=1", sa); end
    total++; if (nan !== 53'h18000000000001) begin bad++; $display("FAIL release_nan got=%h exp=18000000000001", nan); end
  endtask

  task automatic test_single_normal();
    FA2 = {32'h428A0000, 32'h0}; FB2 = {32'h428A0000, 32'h0}; db = 1'b0; normal = 1'b1;
    step();
    $display("txn single_normal: FA2=%h", FA2);
    total++; if (sa !== 1'b0) begin bad++; $display("FAIL sn_sa got=%b exp=0", sa); end
    total++; if (ea !== 11'h006) begin bad++; $display("FAIL sn_ea got=%h exp=006", ea); end
    total++; if (fa !== 53'h11400000000000) begin bad++; $display("FAIL sn_fa got=%h exp=11400000000000", fa); end
    total++; if (lza !== 6'd0) begin bad++; $display("FAIL sn_lza got=%0d exp=0", lza); end
    total++; if (fla !== 4'b0000) begin bad++; $display("FAIL sn_fla got=%b exp=0000", fla); end
    total++; if ({sb, eb, lzb, flb} !== {1'b0, 11'h006, 6'd0, 4'b0000}) begin bad++; $display("FAIL sn_b_fields got=%h exp=%h", {sb, eb, lzb, flb}, {1'b0, 11'h006, 6'd0, 4'b0000}); end
    total++; if (fb !== 53'h11400000000000) begin bad++; $display("FAIL sn_fb got=%h exp=11400000000000", fb); end
    total++; if (nan !== 53'h08000000000000) begin bad++; $display("FAIL sn_nan got=%h exp=08000000000000", nan); end
  endtask

  task automatic test_double_denormal();
    FA2 = 64'h1; FB2 = 64'h0; db = 1'b1; normal = 1'b1;
    step();
    $display("txn double_denormal normal=1: FA2=%h", FA2);
    total++; if (ea !== 11'h402) begin bad++; $display("FAIL dd_ea got=%h exp=402", ea); end
    total++; if (lza !== 6'd52) begin bad++; $display("FAIL dd_lza got=%0d exp=52", lza); end
    total++; if (fa !== 53'h10000000000000) begin bad++; $display("FAIL dd_fa_norm got=%h exp=10000000000000", fa); end
    total++; if (fla !== 4'b0000) begin bad++; $display("FAIL dd_fla got=%b exp=0000", fla); end
    total++; if (flb !== 4'b1000) begin bad++; $display("FAIL dd_flb_zero got=%b exp=1000", flb); end
    normal = 1'b0;
    step();
    $display("txn double_denormal normal=0: FA2=%h", FA2);
    total++; if (fa !== 53'h1) begin bad++; $display("FAIL dd_fa_raw got=%h exp=1", fa); end
    total++; if (lza !== 6'd52) begin bad++; $display("FAIL dd_lza_raw got=%0d exp=52", lza); end
  endtask

  task automatic test_zero_inf();
    FA2 = 64'h8000000000000000; FB2 = 64'h7FF0000000000000; db = 1'b1; normal = 1'b1;
    step();
    $display("txn zero_inf: FA2=%h FB2=%h", FA2, FB2);
    total++; if (sa !== 1'b1) begin bad++; $display("FAIL zi_sa got=%b exp=1", sa); end
    total++; if (fla !== 4'b1000) begin bad++; $display("FAIL zi_fla got=%b exp=1000", fla); end
    total++; if (lza !== 6'd53) begin bad++; $display("FAIL zi_lza got=%0d exp=53", lza); end
    total++; if (fa !== 53'h0) begin bad++; $display("FAIL zi_fa got=%h exp=0", fa); end
    total++; if (flb !== 4'b0100) begin bad++; $display("FAIL zi_flb got=%b exp=0100", flb); end
    total++; if (eb !== 11'h400) begin bad++; $display("FAIL zi_eb got=%h exp=400", eb); end
    total++; if (fb !== 53'h10000000000000) begin bad++; $display("FAIL zi_fb got=%h exp=10000000000000", fb); end
    total++; if (nan !== 53'h08000000000000) begin bad++; $display("FAIL zi_nan got=%h exp=08000000000000", nan); end
  endtask

  task automatic test_nan_prop();
    FA2 = 64'h3FF0000000000000; FB2 = 64'hFFF0000000000001; db = 1'b1; normal = 1'b0;
    step();
    $display("txn nan_b: FA2=%h FB2=%h", FA2, FB2);
    total++; if (flb !== 4'b0011) begin bad++; $display("FAIL np_flb got=%b exp=0011", flb); end
    total++; if (ea !== 11'h000) begin bad++; $display("FAIL np_ea_one got=%h exp=000", ea); end
    total++; if (nan !== 53'h18000000000001) begin bad++; $display("FAIL np_nan_b got=%h exp=18000000000001", nan); end
    FA2 = 64'h7FF8000000000002;
    step();
    $display("txn nan_a_wins: FA2=%h FB2=%h", FA2, FB2);
    total++; if (fla !== 4'b0010) begin bad++; $display("FAIL np_fla got=%b exp=0010", fla); end
    total++; if (nan !== 53'h08000000000002) begin bad++; $display("FAIL np_nan_a got=%h exp=08000000000002", nan); end
  endtask

  task automatic test_single_specials();
    FA2 = {32'h7F800000, 32'h0}; FB2 = {32'h3F800000, 32'h0}; db = 1'b0; normal = 1'b1;
    step();
    $display("txn single_inf: FA2=%h", FA2);
    total++; if (fla !== 4'b0100) begin bad++; $display("FAIL ss_fla_inf got=%b exp=0100", fla); end
    total++; if (ea !== 11'h080) begin bad++; $display("FAIL ss_ea got=%h exp=080", ea); end
    total++; if (eb !== 11'h000) begin bad++; $display("FAIL ss_eb_one got=%h exp=000", eb); end
    FA2 = {32'h7FC00000, 32'h0};
    step();
    $display("txn single_qnan: FA2=%h", FA2);
    total++; if (fla !== 4'b0010) begin bad++; $display("FAIL ss_fla_nan got=%b exp=0010", fla); end
    total++; if (nan !== 53'h08000000000000) begin bad++; $display("FAIL ss_nan got=%h exp=08000000000000", nan); end
  endtask

  task automatic test_back_to_back();
    // Same operand, format and mode change every cycle; low word must be ignored in single.
    FA2 = 64'h1; FB2 = 64'h1; db = 1'b1; normal = 1'b1;
    step();
    $display("txn b2b_0: db=%b normal=%b", db, normal);
    total++; if (fa !== 53'h10000000000000) begin bad++; $display("FAIL b2b0_fa got=%h exp=10000000000000", fa); end
    db = 1'b0; normal = 1'b1;
    step();
    $display("txn b2b_1: db=%b normal=%b", db, normal);
    total++; if (fla !== 4'b1000) begin bad++; $display("FAIL b2b1_fla got=%b exp=1000", fla); end
    total++; if (ea !== 11'h782) begin bad++; $display("FAIL b2b1_ea got=%h exp=782", ea); end
    total++; if (lzb !== 6'd53) begin bad++; $display("FAIL b2b1_lzb got=%0d exp=53", lzb); end
    db = 1'b1; normal = 1'b0;
    step();
    $display("txn b2b_2: db=%b normal=%b", db, normal);
    total++; if (fb !== 53'h1) begin bad++; $display("FAIL b2b2_fb got=%h exp=1", fb); end
    total++; if (eb !== 11'h402) begin bad++; $display("FAIL b2b2_eb got=%h exp=402", eb); end
  endtask

  initial begin
    rst = 1'b1; FA2 = '0; FB2 = '0; db = 1'b0; normal = 1'b0;
    test_reset();
    test_single_normal();
    test_double_denormal();
    test_zero_inf();
    test_nan_prop();
    test_single_specials();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
